// File: rtl/spec_accum_pkg.sv
// Shared types, default geometry and arithmetic helpers for the range-gate
// power-spectrum accumulator.
package spec_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FFT_LEN_DEF   = 1024;
  localparam int NUM_GATES_DEF = 8;
  localparam int BIN_W         = $clog2(FFT_LEN_DEF);
  localparam int GATE_W        = $clog2(NUM_GATES_DEF);
  localparam int ADDR_W        = $clog2(NUM_GATES_DEF * FFT_LEN_DEF);

  // Largest unsigned value representable in w bits (w < 64).
  function automatic logic [63:0] sat_limit(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = sat_limit(w);
    return (sum > {1'b0, lim}) ? lim : sum[63:0];
  endfunction

  function automatic logic [63:0] shift_sat(input logic [63:0] acc, input logic [5:0] sh,
                                            input int w);
    logic [63:0] r;
    logic [63:0] lim;
    r   = acc >> sh;
    lim = sat_limit(w);
    return (r > lim) ? lim : r;
  endfunction

endpackage

// File: rtl/spec_accum_if.sv
// Readout stream of the accumulator: ready/valid words tagged with gate/bin.
interface spec_accum_if
  import spec_accum_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int BW    = BIN_W,
  parameter int GW    = GATE_W
) ();

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [BW-1:0]    out_bin;
  logic [GW-1:0]    out_gate;
  logic             out_last;

  modport master (output out_valid, out_data, out_bin, out_gate, out_last,
                  input  out_ready);
  modport slave  (input  out_valid, out_data, out_bin, out_gate, out_last,
                  output out_ready);

endinterface

// File: rtl/spec_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
module spec_acc_ram
  import spec_accum_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = NUM_GATES_DEF * FFT_LEN_DEF,
  parameter int AW    = ADDR_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: storage arrays carry no reset so they map onto block RAM; the
  // first pulse of every frame overwrites whatever they held.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spec_accum_bank.sv
// Multi-gate power-spectrum accumulator: RMW accumulation over pulses, then a
// back-pressured drain of (acc >> shift) through a two-entry skid buffer.
module spec_accum_bank
  import spec_accum_pkg::*;
#(
  parameter int FFT_LEN   = 1024,
  parameter int NUM_GATES = 8,
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [15:0]                  acc_num_i,
  input  logic [$clog2(NUM_GATES):0]   gate_num_i,
  input  logic [5:0]                   shift_i,
  input  logic                         spec_valid_i,
  input  logic [DATA_W-1:0]            spec_data_i,
  spec_accum_if.master                 out_if,
  output logic                         busy_o,
  output logic                         overrun_o
);

  localparam int BW  = $clog2(FFT_LEN);
  localparam int GW  = $clog2(NUM_GATES);
  localparam int AW  = BW + GW;
  localparam int GNW = GW + 1;

  typedef struct packed {
    logic [GW-1:0] gate;
    logic [BW-1:0] bin;
    logic          last;
  } tag_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    tag_t             tag;
  } word_t;

  state_e state_q, state_d;
  logic [15:0] acc_num_q, pulse_q;
  logic [GNW-1:0] gate_num_q, gate_num_cl;
  logic [5:0] shift_q;
  logic [BW-1:0] bin_q, rd_bin_q;
  logic [GW-1:0] gate_q, rd_gate_q;
  logic in_done_q, rd_done_q, rd_pend_q, overrun_q;
  logic s1_valid_q, s1_first_q, s1_last_q, s2_valid_q, s2_last_q;
  logic [AW-1:0] s1_addr_q, s2_addr_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [ACC_W-1:0] s2_data_q, acc_sum, ram_rdata;
  tag_t rd_tag_q;
  word_t fifo_q [2];
  word_t head;
  logic rptr_q, wptr_q;
  logic [1:0] cnt_q;
  logic accept, bin_end, gate_end, final_beat, rd_last, pop, issue;
  logic [2:0] occ;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gate_num_cl = gate_num_i;
    if (gate_num_i == '0) gate_num_cl = GNW'(1);
    else if (gate_num_i > GNW'(NUM_GATES)) gate_num_cl = GNW'(NUM_GATES);
  end

  assign accept     = (state_q == ACCUM) && spec_valid_i && !in_done_q && !start_i;
  assign bin_end    = (bin_q == BW'(FFT_LEN - 1));
  assign gate_end   = (GNW'(gate_q) == gate_num_q - GNW'(1));
  assign final_beat = bin_end && gate_end && (pulse_q == acc_num_q - 16'd1);
  assign rd_last    = (rd_bin_q == BW'(FFT_LEN - 1)) &&
                      (GNW'(rd_gate_q) == gate_num_q - GNW'(1));
  assign head       = fifo_q[rptr_q];
  assign pop        = (cnt_q != 2'd0) && out_if.out_ready;
  // Reads in flight plus buffered words never exceed the two skid entries.
  assign occ        = {1'b0, cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign issue      = (state_q == DRAIN) && !rd_done_q && !start_i && (occ < 3'd2);
  assign acc_sum    = s1_first_q ? ACC_W'(s1_data_q)
                                 : ACC_W'(sat_add(64'(ram_rdata), 64'(s1_data_q), ACC_W));

  spec_acc_ram #(.WIDTH(ACC_W), .DEPTH(NUM_GATES * FFT_LEN), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (s2_valid_q),
    .waddr_i (s2_addr_q),
    .wdata_i (s2_data_q),
    .re_i    ((accept && (pulse_q != 16'd0)) || issue),
    .raddr_i ((state_q == DRAIN) ? {rd_gate_q, rd_bin_q} : {gate_q, bin_q}),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    if (start_i) state_d = ACCUM;
    else begin
      case (state_q)
        ACCUM:   if (s2_valid_q && s2_last_q) state_d = DRAIN;
        DRAIN:   if (pop && head.tag.last) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      acc_num_q  <= 16'd1;
      gate_num_q <= GNW'(1);
      shift_q    <= '0;
      bin_q      <= '0;
      gate_q     <= '0;
      pulse_q    <= '0;
      in_done_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_i) overrun_q <= 1'b0;
      else if (spec_valid_i && !accept) overrun_q <= 1'b1;
      if (start_i) begin
        acc_num_q  <= (acc_num_i == 16'd0) ? 16'd1 : acc_num_i;
        gate_num_q <= gate_num_cl;
        shift_q    <= shift_i;
        bin_q      <= '0;
        gate_q     <= '0;
        pulse_q    <= '0;
        in_done_q  <= 1'b0;
      end else if (accept) begin
        if (final_beat) in_done_q <= 1'b1;
        if (bin_end) begin
          bin_q <= '0;
          if (gate_end) begin
            gate_q  <= '0;
            pulse_q <= pulse_q + 16'd1;
          end else gate_q <= gate_q + GW'(1);
        end else bin_q <= bin_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_first_q <= (pulse_q == 16'd0);
      s1_last_q  <= final_beat;
      s1_addr_q  <= {gate_q, bin_q};
      s1_data_q  <= spec_data_i;
      s2_valid_q <= s1_valid_q && !start_i;
      s2_last_q  <= s1_last_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= acc_sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_bin_q  <= '0;
      rd_gate_q <= '0;
      rd_done_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rptr_q    <= 1'b0;
      wptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (start_i) begin
      rd_bin_q  <= '0;
      rd_gate_q <= '0;
      rd_done_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rptr_q    <= 1'b0;
      wptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      rd_pend_q <= issue;
      if (issue) begin
        rd_tag_q <= '{gate: rd_gate_q, bin: rd_bin_q, last: rd_last};
        if (rd_last) rd_done_q <= 1'b1;
        if (rd_bin_q == BW'(FFT_LEN - 1)) begin
          rd_bin_q  <= '0;
          rd_gate_q <= rd_gate_q + GW'(1);
        end else rd_bin_q <= rd_bin_q + BW'(1);
      end
      if (rd_pend_q) begin
        fifo_q[wptr_q] <= '{data: OUT_W'(shift_sat(64'(ram_rdata), shift_q, OUT_W)),
                           tag: rd_tag_q};
        wptr_q <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

  assign out_if.out_valid = (cnt_q != 2'd0);
  assign out_if.out_data  = head.data;
  assign out_if.out_bin   = head.tag.bin;
  assign out_if.out_gate  = head.tag.gate;
  assign out_if.out_last  = head.tag.last && (cnt_q != 2'd0);
  assign busy_o           = (state_q != IDLE);
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_spec_accum_bank.sv
// Directed bench for spec_accum_bank: accumulate/drain frames, saturation,
// back-pressure, overrun, abort and mid-drain reset.
module tb_spec_accum_bank;

  localparam int FFT_LEN   = 16;
  localparam int NUM_GATES = 4;
  localparam int DATA_W    = 32;
  localparam int ACC_W     = 34;
  localparam int OUT_W     = 32;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;
  localparam logic [63:0] OUT_MAX = (64'd1 << OUT_W) - 64'd1;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              start_i;
  logic [15:0]       acc_num_i;
  logic [2:0]        gate_num_i;
  logic [5:0]        shift_i;
  logic              spec_valid_i;
  logic [DATA_W-1:0] spec_data_i;
  logic              busy_o;
  logic              overrun_o;

  spec_accum_if #(.OUT_W(OUT_W), .BW(4), .GW(2)) out_if ();

  spec_accum_bank #(
    .FFT_LEN(FFT_LEN), .NUM_GATES(NUM_GATES), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .acc_num_i    (acc_num_i),
    .gate_num_i   (gate_num_i),
    .shift_i      (shift_i),
    .spec_valid_i (spec_valid_i),
    .spec_data_i  (spec_data_i),
    .out_if       (out_if),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Active frame description used by the reference model.
  int          mode;
  logic [31:0] cval;
  int          acc_eff;
  int          gnum_eff;
  int          sh_cfg;
  int          span;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] in_val(input int g, input int b, input int p);
    case (mode)
      0:       return cval;
      1:       return 32'(b);
      default: return 32'(g * 1000 + b * 7 + p);
    endcase
  endfunction

  function automatic logic [63:0] exp_out(input int k);
    logic [63:0] acc;
    int g, b;
    g   = k / FFT_LEN;
    b   = k % FFT_LEN;
    acc = 64'd0;
    for (int p = 0; p < acc_eff; p++) begin
      acc = acc + 64'(in_val(g, b, p));
      if (acc > ACC_MAX) acc = ACC_MAX;
    end
    acc = acc >> sh_cfg;
    return (acc > OUT_MAX) ? OUT_MAX : acc;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [15:0] an, input logic [2:0] gn, input logic [5:0] sh);
    start_i    = 1'b1;
    acc_num_i  = an;
    gate_num_i = gn;
    shift_i    = sh;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic feed(input int limit, input bit gap);
    int cnt;
    cnt = 0;
    for (int p = 0; p < acc_eff; p++) begin
      for (int g = 0; g < gnum_eff; g++) begin
        for (int b = 0; b < FFT_LEN; b++) begin
          if (cnt == limit) begin
            spec_valid_i = 1'b0;
            return;
          end
          spec_valid_i = 1'b1;
          spec_data_i  = in_val(g, b, p);
          tick();
          cnt++;
        end
        if (gap) begin
          spec_valid_i = 1'b0;
          tick();
        end
      end
    end
    spec_valid_i = 1'b0;
  endtask

  task automatic drain(input int ready_pct, input int inject_cyc, input int stop_after,
                       output int hs_span);
    int n, k, cyc, first_hs, last_hs;
    logic stalled;
    logic [63:0] held_data, held_tag, cur_tag, exp_tag;
    n = gnum_eff * FFT_LEN;
    k = 0;
    cyc = 0;
    first_hs = -1;
    last_hs = 0;
    stalled = 1'b0;
    held_data = '0;
    held_tag = '0;
    while (k < stop_after && cyc < 4000) begin
      out_if.out_ready = ($urandom_range(0, 99) < ready_pct);
      spec_valid_i     = (cyc == inject_cyc);
      spec_data_i      = 32'hDEAD_BEEF;
      @(negedge clk_i);
      cur_tag = 64'({out_if.out_gate, out_if.out_bin, out_if.out_last});
      if (stalled) begin
        check("hold_valid", 64'(out_if.out_valid), 64'd1);
        check("hold_data", 64'(out_if.out_data), held_data);
        check("hold_tag", cur_tag, held_tag);
      end
      if (out_if.out_valid && out_if.out_ready) begin
        exp_tag = 64'(((k / FFT_LEN) << 5) | ((k % FFT_LEN) << 1) | ((k == n - 1) ? 1 : 0));
        check("word_data", 64'(out_if.out_data), exp_out(k));
        check("word_tag", cur_tag, exp_tag);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        k++;
      end
      stalled   = out_if.out_valid && !out_if.out_ready;
      held_data = 64'(out_if.out_data);
      held_tag  = cur_tag;
      tick();
      cyc++;
    end
    out_if.out_ready = 1'b0;
    spec_valid_i     = 1'b0;
    check("drain_count", 64'(k), 64'(stop_after));
    hs_span = last_hs - first_hs;
  endtask

  initial begin
    rst_n_i          = 1'b0;
    start_i          = 1'b0;
    acc_num_i        = '0;
    gate_num_i       = '0;
    shift_i          = '0;
    spec_valid_i     = 1'b0;
    spec_data_i      = '0;
    out_if.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_overrun", 64'(overrun_o), 64'd0);
    check("rst_valid", 64'(out_if.out_valid), 64'd0);
    check("rst_last", 64'(out_if.out_last), 64'd0);
    check("rst_data", 64'(out_if.out_data), 64'd0);
    check("rst_tag", 64'({out_if.out_gate, out_if.out_bin}), 64'd0);
    rst_n_i = 1'b1;
    tick();

    // A: constant 100, 4 pulses, 2 gates, shift 2 -> 32 words of 100, full rate
    mode = 0; cval = 32'd100; acc_eff = 4; gnum_eff = 2; sh_cfg = 2;
    do_start(16'd4, 3'd2, 6'd2);
    check("busy_accum", 64'(busy_o), 64'd1);
    feed(1 << 30, 1'b0);
    drain(100, -1, 32, span);
    check("full_rate_span", 64'(span), 64'd31);
    check("busy_fall", 64'(busy_o), 64'd0);
    check("no_overrun", 64'(overrun_o), 64'd0);
    out_if.out_ready = 1'b1;
    @(negedge clk_i);
    check("no_extra_word", 64'(out_if.out_valid), 64'd0);
    tick();
    out_if.out_ready = 1'b0;

    // B: input = bin, 3 pulses, shift 0 -> 3*bin, old frame fully overwritten
    mode = 1; acc_eff = 3; gnum_eff = 2; sh_cfg = 0;
    do_start(16'd3, 3'd2, 6'd0);
    feed(1 << 30, 1'b0);
    drain(100, -1, 32, span);

    // C: 8 x (2^32-1) saturates the 34-bit accumulator
    mode = 0; cval = 32'hFFFF_FFFF; acc_eff = 8; gnum_eff = 1; sh_cfg = 3;
    do_start(16'd8, 3'd1, 6'd3);
    feed(1 << 30, 1'b0);
    drain(100, -1, 16, span);
    sh_cfg = 0;
    do_start(16'd8, 3'd1, 6'd0);
    feed(1 << 30, 1'b0);
    drain(100, -1, 16, span);

    // D: gate_num 7 clamps to 4, gapped input, 50% ready
    mode = 2; acc_eff = 5; gnum_eff = 4; sh_cfg = 1;
    do_start(16'd5, 3'd7, 6'd1);
    feed(1 << 30, 1'b1);
    drain(50, -1, 64, span);

    // E: zero counts map to 1; spec_valid during DRAIN raises overrun only
    mode = 1; acc_eff = 1; gnum_eff = 1; sh_cfg = 0;
    do_start(16'd0, 3'd0, 6'd0);
    feed(1 << 30, 1'b0);
    drain(100, 10, 16, span);
    check("overrun_set", 64'(overrun_o), 64'd1);

    // F: start mid-ACCUM aborts; the restarted frame is clean
    mode = 0; cval = 32'd5; acc_eff = 3; gnum_eff = 2; sh_cfg = 0;
    do_start(16'd3, 3'd2, 6'd0);
    check("overrun_cleared", 64'(overrun_o), 64'd0);
    feed(20, 1'b0);
    mode = 1; acc_eff = 2; gnum_eff = 2; sh_cfg = 0;
    do_start(16'd2, 3'd2, 6'd0);
    feed(1 << 30, 1'b0);
    drain(100, -1, 32, span);

    // G: reset in the middle of DRAIN
    mode = 0; cval = 32'd9; acc_eff = 2; gnum_eff = 1; sh_cfg = 0;
    do_start(16'd2, 3'd1, 6'd0);
    feed(1 << 30, 1'b0);
    drain(100, -1, 5, span);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_valid", 64'(out_if.out_valid), 64'd0);
    check("mid_rst_data", 64'(out_if.out_data), 64'd0);
    check("mid_rst_tag", 64'({out_if.out_gate, out_if.out_bin, out_if.out_last}), 64'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    mode = 2; acc_eff = 2; gnum_eff = 2; sh_cfg = 0;
    do_start(16'd2, 3'd2, 6'd0);
    feed(1 << 30, 1'b0);
    drain(70, -1, 32, span);
    check("final_busy", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
